// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: base opcodes, the reset NOP and the fetch FSM states.
package riscv_pkg;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel: strobe/address out, data/ack back.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            mem_rd_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [31:0]     mem_rdata_i;
    logic            mem_ack_i;

    modport master (
        output mem_rd_o,
        output mem_addr_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_rd_o,
        input  mem_addr_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

// File: rtl/ifu_timeout_ctr.sv
// Counts WAIT cycles without an ack; expired_o flags the last allowed cycle.
module ifu_timeout_ctr #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instructions over a rd/ack channel and holds INSTR.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int unsigned     TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req_i,
    input  logic               pc_write_i,
    input  logic [XLEN-1:0]    branch_target_i,
    instr_fetch_unit_if.master mem,
    output logic [31:0]        instr_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    pc_cur_o,
    output logic [6:0]         opcode_o,
    output logic [4:0]         rd_o,
    output logic [2:0]         funct3_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic [6:0]         funct7_o,
    output logic               instr_valid_o,
    output logic               busy_o,
    output logic               fetch_err_o
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_cur_q, pc_cur_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            mem_rd_q, mem_rd_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            err_q, err_d;
    logic            pending_q, pending_d;
    logic [XLEN-1:0] target_q, target_d;

    logic [XLEN-1:0] fetch_addr_s;
    logic            ctr_clear_s;
    logic            ctr_en_s;
    logic            ctr_expired_s;

    ifu_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (ctr_clear_s),
        .en_i      (ctr_en_s),
        .expired_o (ctr_expired_s)
    );

    assign fetch_addr_s = pc_write_i ? branch_target_i : pc_q;

    // Fetch FSM next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_cur_d      = pc_cur_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        mem_rd_d      = mem_rd_q;
        mem_addr_d    = mem_addr_q;
        err_d         = err_q;
        pending_d     = pending_q;
        target_d      = target_q;
        ctr_clear_s   = 1'b0;
        ctr_en_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_req_i) begin
                    if (fetch_addr_s[1:0] != 2'b00) begin
                        state_d       = ST_ERR;
                        err_d         = 1'b1;
                        instr_valid_d = 1'b0;
                    end else begin
                        state_d       = ST_WAIT;
                        mem_rd_d      = 1'b1;
                        mem_addr_d    = fetch_addr_s;
                        pc_d          = fetch_addr_s;
                        instr_valid_d = 1'b0;
                        ctr_clear_s   = 1'b1;
                    end
                end else if (pc_write_i) begin
                    pc_d = branch_target_i;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_WAIT: begin
                if (mem.mem_ack_i) begin
                    state_d       = ST_IDLE;
                    instr_d       = mem.mem_rdata_i;
                    pc_cur_d      = mem_addr_q;
                    instr_valid_d = 1'b1;
                    mem_rd_d      = 1'b0;
                    pending_d     = 1'b0;
                    // A branch arriving with the ack overrides any earlier pending one.
                    if (pc_write_i) begin
                        pc_d = branch_target_i;
                    end else if (pending_q) begin
                        pc_d = target_q;
                    end else begin
                        pc_d = mem_addr_q + XLEN'(4);
                    end
                end else begin
                    if (pc_write_i) begin
                        target_d  = branch_target_i;
                        pending_d = 1'b1;
                    end else begin
                        target_d  = target_q;
                    end
                    if (ctr_expired_s) begin
                        state_d  = ST_ERR;
                        mem_rd_d = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        ctr_en_s = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                mem_rd_d      = 1'b0;
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d       = ST_ERR;
                mem_rd_d      = 1'b0;
                instr_valid_d = 1'b0;
                err_d         = 1'b1;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pc_cur_q      <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            err_q         <= 1'b0;
            pending_q     <= 1'b0;
            target_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_cur_q      <= pc_cur_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            err_q         <= err_d;
            pending_q     <= pending_d;
            target_q      <= target_d;
        end
    end

    assign mem.mem_rd_o   = mem_rd_q;
    assign mem.mem_addr_o = mem_addr_q;
    assign instr_o        = instr_q;
    assign pc_o           = pc_q;
    assign pc_cur_o       = pc_cur_q;
    assign instr_valid_o  = instr_valid_q;
    assign busy_o         = (state_q == ST_WAIT);
    assign fetch_err_o    = err_q;
    assign opcode_o       = instr_q[6:0];
    assign rd_o           = instr_q[11:7];
    assign funct3_o       = instr_q[14:12];
    assign rs1_o          = instr_q[19:15];
    assign rs2_o          = instr_q[24:20];
    assign funct7_o       = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, corner-case sequences, random run vs. a reference model.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic        pc_write = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] instr, pc, pc_cur;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        instr_valid, busy, fetch_err;

    int checks = 0;
    int failures = 0;

    instr_fetch_unit_if #(.XLEN(32)) mem_if ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req_i     (fetch_req),
        .pc_write_i      (pc_write),
        .branch_target_i (branch_target),
        .mem             (mem_if.master),
        .instr_o         (instr),
        .pc_o            (pc),
        .pc_cur_o        (pc_cur),
        .opcode_o        (opcode),
        .rd_o            (rd),
        .funct3_o        (funct3),
        .rs1_o           (rs1),
        .rs2_o           (rs2),
        .funct7_o        (funct7),
        .instr_valid_o   (instr_valid),
        .busy_o          (busy),
        .fetch_err_o     (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        req, pcw;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        rd;
        logic [31:0] addr, pc, cur, instr;
        logic        valid, busy, err;
    } vec_t;

    vec_t vecs[15];

    // Reference model: one fetch transaction at a time, counted in whole cycles.
    logic [31:0] m_pc, m_cur, m_instr, m_addr, m_tgt;
    logic        m_valid, m_busy, m_err, m_has_tgt;
    int          m_wait;

    function automatic vec_t mk(logic req, logic pcw, logic [31:0] tgt, logic ack, logic [31:0] rdata,
                                logic e_rd, logic [31:0] e_addr, logic [31:0] e_pc, logic [31:0] e_cur,
                                logic [31:0] e_instr, logic e_valid, logic e_busy, logic e_err);
        vec_t v;
        v.req = req; v.pcw = pcw; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
        v.rd = e_rd; v.addr = e_addr; v.pc = e_pc; v.cur = e_cur; v.instr = e_instr;
        v.valid = e_valid; v.busy = e_busy; v.err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_rd, input logic [31:0] e_addr,
                             input logic [31:0] e_pc, input logic [31:0] e_cur, input logic [31:0] e_instr,
                             input logic e_valid, input logic e_busy, input logic e_err);
        chk({tag, ".mem_rd"}, {31'h0, mem_if.mem_rd_o}, {31'h0, e_rd});
        chk({tag, ".mem_addr"}, mem_if.mem_addr_o, e_addr);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".pc_cur"}, pc_cur, e_cur);
        chk({tag, ".instr"}, instr, e_instr);
        chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, e_valid});
        chk({tag, ".busy"}, {31'h0, busy}, {31'h0, e_busy});
        chk({tag, ".err"}, {31'h0, fetch_err}, {31'h0, e_err});
        chk({tag, ".fields"}, {funct7, rs2, rs1, funct3, rd, opcode}, e_instr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic req, input logic pcw, input logic [31:0] tgt,
                          input logic ack, input logic [31:0] rdata);
        fetch_req = req; pc_write = pcw; branch_target = tgt;
        mem_if.mem_ack_i = ack; mem_if.mem_rdata_i = rdata;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_cur = 32'h0; m_instr = NOP_INSTR; m_addr = 32'h0; m_tgt = 32'h0;
        m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_has_tgt = 1'b0; m_wait = 0;
    endtask

    task automatic model_step(input logic req, input logic pcw, input logic [31:0] tgt,
                              input logic ack, input logic [31:0] rdata);
        logic [31:0] a;
        if (m_err) return;
        if (!m_busy) begin
            if (req) begin
                a = pcw ? tgt : m_pc;
                if (a % 4 != 0) begin
                    m_err = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_busy = 1'b1; m_addr = a; m_pc = a; m_valid = 1'b0; m_wait = 0;
                end
            end else if (pcw) begin
                m_pc = tgt;
            end
        end else if (ack) begin
            m_instr = rdata; m_cur = m_addr; m_valid = 1'b1; m_busy = 1'b0;
            m_pc = pcw ? tgt : (m_has_tgt ? m_tgt : m_addr + 32'd4);
            m_has_tgt = 1'b0;
        end else begin
            if (pcw) begin
                m_tgt = tgt;
                m_has_tgt = 1'b1;
            end
            m_wait++;
            if (m_wait >= TIMEOUT) begin
                m_err = 1'b1;
                m_busy = 1'b0;
            end
        end
    endtask

    initial begin
        mem_if.mem_ack_i = 1'b0;
        mem_if.mem_rdata_i = 32'h0;

        vecs[0]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        32'h0000_0013, 0, 1, 0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 32'h00A00093, 0, 32'h0,        32'h4,        32'h0,        32'h00A00093, 1, 0, 0);
        vecs[2]  = mk(0, 1, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h00A00093, 1, 0, 0);
        vecs[3]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        32'h00A00093, 0, 1, 0);
        vecs[4]  = mk(0, 1, 32'h40,       0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        32'h00A00093, 0, 1, 0);
        vecs[5]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        32'h00A00093, 0, 1, 0);
        vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        32'h00A00093, 0, 1, 0);
        vecs[7]  = mk(0, 0, 32'h0,        1, 32'h002081B3, 0, 32'h0,        32'h40,       32'h0,        32'h002081B3, 1, 0, 0);
        vecs[8]  = mk(1, 1, 32'h80,       0, 32'h0,        1, 32'h80,       32'h80,       32'h0,        32'h002081B3, 0, 1, 0);
        vecs[9]  = mk(0, 0, 32'h0,        1, 32'h0000A103, 0, 32'h80,       32'h84,       32'h80,       32'h0000A103, 1, 0, 0);
        vecs[10] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h84,       32'h84,       32'h80,       32'h0000A103, 0, 1, 0);
        vecs[11] = mk(0, 1, 32'h200,      0, 32'h0,        1, 32'h84,       32'h84,       32'h80,       32'h0000A103, 0, 1, 0);
        vecs[12] = mk(0, 1, 32'h300,      1, 32'hFE208EE3, 0, 32'h84,       32'h300,      32'h84,       32'hFE208EE3, 1, 0, 0);
        vecs[13] = mk(1, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h84,       32'hFE208EE3, 0, 1, 0);
        vecs[14] = mk(0, 0, 32'h0,        1, 32'h00000013, 0, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 32'h00000013, 1, 0, 0);

        // Reset state
        do_reset();
        check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, NOP_INSTR, 1'b0, 1'b0, 1'b0);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].req, vecs[i].pcw, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].pc, vecs[i].cur,
                      vecs[i].instr, vecs[i].valid, vecs[i].busy, vecs[i].err);
        end
        chk("vec1.opcode_imm", {25'h0, vecs[1].rdata[6:0]}, {25'h0, OP_IMM});

        // Ack timeout, then fetch_req ignored in ERR
        do_reset();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check_all("to.last_wait", 1'b1, 32'h0, 32'h0, 32'h0, NOP_INSTR, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("to.expired", 1'b0, 32'h0, 32'h0, 32'h0, NOP_INSTR, 1'b0, 1'b0, 1'b1);
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h12345678);
        tick();
        tick();
        check_all("to.err_hold", 1'b0, 32'h0, 32'h0, 32'h0, NOP_INSTR, 1'b0, 1'b0, 1'b1);

        // Ack in the final allowed cycle wins over timeout
        do_reset();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h00A00093);
        tick();
        check_all("to.ack_wins", 1'b0, 32'h0, 32'h4, 32'h0, 32'h00A00093, 1'b1, 1'b0, 1'b0);

        // Misaligned PC: error without any read strobe
        do_reset();
        set_in(1'b0, 1'b1, 32'h102, 1'b0, 32'h0);
        tick();
        check_all("mis.pcw", 1'b0, 32'h0, 32'h102, 32'h0, NOP_INSTR, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check_all("mis.err", 1'b0, 32'h0, 32'h102, 32'h0, NOP_INSTR, 1'b0, 1'b0, 1'b1);
        set_in(1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mis.no_rd%0d", i), {31'h0, mem_if.mem_rd_o}, 32'h0);
        end
        chk("mis.pc_frozen", pc, 32'h102);

        // Async reset mid-WAIT, late ack ignored
        do_reset();
        set_in(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        tick();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("rst.pre_rd", {31'h0, mem_if.mem_rd_o}, 32'h1);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst.async_rd", {31'h0, mem_if.mem_rd_o}, 32'h0);
        chk("rst.async_pc", pc, 32'h0);
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
        tick();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_all("rst.late_ack", 1'b0, 32'h0, 32'h0, 32'h0, NOP_INSTR, 1'b0, 1'b0, 1'b0);

        // Random run against the reference model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_err || (cyc % 250) == 249) begin
                do_reset();
                model_reset();
            end
            fetch_req = ($urandom_range(0, 2) == 0);
            pc_write = ($urandom_range(0, 4) == 0);
            branch_target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 40) == 0) branch_target[1:0] = 2'($urandom_range(1, 3));
            mem_if.mem_ack_i = mem_if.mem_rd_o && ($urandom_range(0, 2) == 0);
            mem_if.mem_rdata_i = $urandom;
            model_step(fetch_req, pc_write, branch_target, mem_if.mem_ack_i, mem_if.mem_rdata_i);
            tick();
            check_all($sformatf("rand%0d", cyc), m_busy, m_addr, m_pc, m_cur, m_instr,
                      m_valid && !m_err, m_busy, m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
